// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event block: FSM state encoding and a
// counter-width helper used by the tick prescaler.
package btn_event_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2
    } btn_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_event_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// clr restarts the count so the next tick lands TICK_DIV cycles later.
module tick_prescaler
    import btn_event_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
        pre_d = pre_q + PW'(1);
        if (clr || (pre_q == LAST)) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = (pre_q == LAST);

endmodule

// File: rtl/btn_event.sv
// Turns the debounced button level into registered one-cycle events
// (press, release, short click, long press, auto-repeat) plus hold time.
//
// state     | meaning
// S_IDLE    | released, or still held from before reset and not yet re-armed
// S_PRESSED | press reported, hold shorter than LONG_T ticks
// S_LONG    | long_press reported, issuing repeat pulses every REP_T ticks
//
// The release event is on port release_p because release is a reserved word.
module btn_event
    import btn_event_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned TW         = 16,
    parameter int unsigned LONG_T     = 800,
    parameter int unsigned REP_T      = 200,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_db,
    output logic          press,
    output logic          release_p,
    output logic          short_click,
    output logic          long_press,
    output logic          repeat_p,
    output logic          held,
    output logic [TW-1:0] hold_cnt
);

    localparam logic [TW-1:0] LONG_C = TW'(LONG_T);
    localparam logic [TW-1:0] REP_C  = TW'(REP_T);

    btn_state_e    state_q, state_d;
    logic          l, l_q, l_d;
    logic          rise, fall, tick;
    logic [TW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
    logic [TW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic          press_q, press_d, release_q, release_d;
    logic          short_q, short_d, long_q, long_d;
    logic          repeat_q, repeat_d, held_q, held_d;

    assign l    = btn_db ^ ACTIVE_LOW;
    assign rise = l & ~l_q;
    assign fall = ~l & l_q;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (rise),
        .tick (tick)
    );

    assign hold_inc = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + TW'(1);
    assign rep_inc  = rep_cnt_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        l_d        = l;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        if (rise) begin
            hold_cnt_d = '0;
        end else if (tick && (state_q != S_IDLE)) begin
            hold_cnt_d = hold_inc;
        end

        // A fall always takes priority over a coincident long/repeat tick.
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    state_d = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    state_d   = S_IDLE;
                end else if (tick && (hold_inc == LONG_C)) begin
                    long_d    = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = S_LONG;
                end
            end
            S_LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (tick) begin
                    rep_cnt_d = rep_inc;
                    if ((REP_T != 0) && (rep_inc == REP_C)) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        held_d = (state_d != S_IDLE);
    end

    // l_q resets to the pressed level so a button held through reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            l_q        <= 1'b1;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            short_q    <= short_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            held_q     <= held_d;
        end
    end

    assign press       = press_q;
    assign release_p   = release_q;
    assign short_click = short_q;
    assign long_press  = long_q;
    assign repeat_p    = repeat_q;
    assign held        = held_q;
    assign hold_cnt    = hold_cnt_q;

endmodule
